eth_tx_arb: RTL
===============

Name: eth_tx_arb

Overview:
Packet-level 2:1 AXI-Stream arbiter feeding the Ethernet MAC transmit port. It merges the science-data stream (s0) and the housekeeping/slow-control stream (s1) into one stream. A grant is held for the whole packet, and a registered skid buffer drives the output. The downstream tready it consumes is the combined MAC/ready-gate signal, so no combinational path runs from m_tready to either s_tready.

Parameters:
DATA_W, 8, tdata width in bits (MAC byte stream)
PRIORITY, 0, 0 = round-robin between s0/s1 at packet boundaries; 1 = s0 strict priority
CNT_W, 16, width of per-source packet counters

Ports:
aclk  in  1  single clock for all logic
aresetn  in  1  synchronous active-low reset
s0_tdata  in  DATA_W  science stream data
s0_tvalid  in  1  science stream valid
s0_tlast  in  1  science stream end of packet
s0_tready  out  1  science stream ready
s1_tdata  in  DATA_W  housekeeping stream data
s1_tvalid  in  1  housekeeping stream valid
s1_tlast  in  1  housekeeping stream end of packet
s1_tready  out  1  housekeeping stream ready
m_tdata  out  DATA_W  to MAC
m_tvalid  out  1  to MAC
m_tlast  out  1  to MAC
m_tready  in  1  combined ready from MAC gate
pkt_cnt0  out  CNT_W  packets forwarded from s0, wraps
pkt_cnt1  out  CNT_W  packets forwarded from s1, wraps
busy  out  1  high while a grant is held

Behaviour:
- Reset: aclk only, synchronous, aresetn=0 sampled on a rising edge.
  - Outputs on reset: s0_tready=0, s1_tready=0, m_tvalid=0, m_tdata=0, m_tlast=0, pkt_cnt0=0, pkt_cnt1=0, busy=0.
  - Internal on reset: FSM=IDLE, skid buffer empty, rr pointer=0 (s0 favoured first).
  - Reset mid-packet aborts the packet. Partial beats are discarded, and no tlast is synthesized.
- FSM states: IDLE, GNT0, GNT1.
  - IDLE: if exactly one sN_tvalid=1, go to GNTN next cycle.
  - IDLE, both valid, PRIORITY=1: go to GNT0.
  - IDLE, both valid, PRIORITY=0: grant the source that was not granted last, i.e. the rr pointer. After reset, s0 wins.
  - GNTN: return to IDLE on the cycle the beat with sN_tlast=1 is accepted (sN_tvalid & sN_tready). Update rr to the other source in the same cycle.
  - Result: exactly one IDLE bubble cycle between packets. A grant is never changed mid-packet.
- Input ready:
  - sN_tready = (state==GNTN) & (skid has ≥1 free slot), driven from registers only.
  - The non-granted source's tready is always 0.
- Skid buffer:
  - 2-entry output register. m_tvalid/m_tdata/m_tlast come from flops.
  - Accepted beats are written in order. Output latency from an input accept to m_tvalid is 1 cycle when the buffer is empty.
  - Full throughput is 1 beat/cycle with m_tready held at 1.
  - m_tready deasserting stalls the output. The buffer absorbs the in-flight beat, then sN_tready drops on the following cycle.
  - AXI rule: once m_tvalid=1, m_tdata/m_tlast are held stable until m_tready=1.
- Counters:
  - pkt_cntN increments by 1 when the sN tlast beat is accepted on the input side.
  - Counters wrap from 2^CNT_W-1 to 0.
- busy = (state != IDLE).
- Single-beat packet (tvalid & tlast on the first beat): sequence is IDLE→GNTN→IDLE, counted once.
- Source drops tvalid mid-packet: the grant is held indefinitely and no timeout applies. The output goes idle (m_tvalid=0) once the buffer drains.
- Simultaneous events: in the cycle a tlast is accepted, the other source's tvalid is not evaluated. Arbitration for it happens in the following IDLE cycle.

Decomposition:
- Shared package eth_pkg holds:
  - state enum (IDLE/GNT0/GNT1)
  - ETH_DATA_W=8 constant
  - PRIO_RR/PRIO_STRICT constants
- One natural sub-module: axis_skid_buf. It is the 2-entry registered buffer, parameterised by width (DATA_W+1 for tlast) and reused elsewhere on the Ethernet path.
- The arbiter FSM and counters stay in eth_tx_arb.

Test Plan:
- Reset then s0 sends 4-beat packet A0..A3 (tlast on A3), m_tready=1 → m_tvalid high on 4 consecutive cycles starting 2 cycles after s0_tvalid; data A0..A3 with m_tlast on A3 only; pkt_cnt0=1, busy back to 0.
- Both sources continuously valid, 3-beat packets, PRIORITY=0 → output packet order is s0,s1,s0,s1; one bubble between packets; after 4 packets pkt_cnt0=2, pkt_cnt1=2.
- Same stimulus with PRIORITY=1 → only s0 packets appear; s1_tready stays 0; pkt_cnt1=0.
- m_tready toggles 1,0,0,1,... during an 8-beat packet → all 8 beats appear in order with none lost or duplicated; m_tdata stable while m_tvalid=1 & m_tready=0; sN_tready=0 within 1 cycle of the buffer filling.
- aresetn=0 for one cycle after beat 2 of a 5-beat s1 packet → next cycle all outputs are 0 and FSM=IDLE; the next s0 packet is forwarded cleanly; pkt_cnt1=0.
- CNT_W=4, 17 single-beat s0 packets → pkt_cnt0 wraps from 15 to 0 and ends at 1; every beat has m_tlast=1.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet transmit path: arbiter states,
// the MAC byte-stream width and the arbitration policy selectors.
package eth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

    localparam int ETH_DATA_W  = 8;
    localparam int PRIO_RR     = 0;
    localparam int PRIO_STRICT = 1;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry registered AXI-Stream buffer. Output comes straight from flops,
// and s_ready depends only on the occupancy register.
module axis_skid_buf #(
    parameter int W = 9
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic [W-1:0] s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [W-1:0] m_data,
    output logic         m_valid,
    input  logic         m_ready
);

    logic [W-1:0] d0_q, d0_d;
    logic [W-1:0] d1_q, d1_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         push;
    logic         pop;

    assign s_ready = (cnt_q != 2'd2);
    assign m_valid = (cnt_q != 2'd0);
    assign m_data  = d0_q;
    assign push    = s_valid & s_ready;
    assign pop     = m_valid & m_ready;

    // Occupancy and entry update; d0 is only rewritten when empty or popping.
    always_comb begin
        d0_d  = d0_q;
        d1_d  = d1_q;
        cnt_d = cnt_q;
        case (cnt_q)
            2'd0: begin
                if (push) begin
                    d0_d  = s_data;
                    cnt_d = 2'd1;
                end else begin
                    cnt_d = 2'd0;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    d0_d = s_data;
                end else if (push) begin
                    d1_d  = s_data;
                    cnt_d = 2'd2;
                end else if (pop) begin
                    cnt_d = 2'd0;
                end else begin
                    cnt_d = 2'd1;
                end
            end
            2'd2: begin
                if (pop) begin
                    d0_d  = d1_q;
                    cnt_d = 2'd1;
                end else begin
                    cnt_d = 2'd2;
                end
            end
            default: cnt_d = 2'd0;
        endcase
    end

    // Buffer registers with synchronous clear.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            d0_q  <= {W{1'b0}};
            d1_q  <= {W{1'b0}};
            cnt_q <= 2'd0;
        end else begin
            d0_q  <= d0_d;
            d1_q  <= d1_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/eth_tx_arb.sv
// Packet-level 2:1 AXI-Stream arbiter for the MAC transmit port: science (s0)
// and housekeeping (s1) streams, grant held for a whole packet.
module eth_tx_arb
    import eth_pkg::*;
#(
    parameter int DATA_W   = ETH_DATA_W,
    parameter int PRIORITY = PRIO_RR,
    parameter int CNT_W    = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [DATA_W-1:0] s0_tdata,
    input  logic              s0_tvalid,
    input  logic              s0_tlast,
    output logic              s0_tready,
    input  logic [DATA_W-1:0] s1_tdata,
    input  logic              s1_tvalid,
    input  logic              s1_tlast,
    output logic              s1_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    output logic              m_tlast,
    input  logic              m_tready,
    output logic [CNT_W-1:0]  pkt_cnt0,
    output logic [CNT_W-1:0]  pkt_cnt1,
    output logic              busy
);

    arb_state_e         state_q, state_d;
    logic               rr_q, rr_d;
    logic [CNT_W-1:0]   cnt0_q, cnt0_d;
    logic [CNT_W-1:0]   cnt1_q, cnt1_d;
    logic               skid_ready;
    logic               in_valid;
    logic [DATA_W:0]    in_data;
    logic [DATA_W:0]    out_data;
    logic               acc0;
    logic               acc1;

    // Both readies are products of flops only, so m_tready never reaches them.
    assign s0_tready = (state_q == GNT0) & skid_ready;
    assign s1_tready = (state_q == GNT1) & skid_ready;
    assign acc0      = s0_tvalid & s0_tready;
    assign acc1      = s1_tvalid & s1_tready;
    assign busy      = (state_q != IDLE);
    assign pkt_cnt0  = cnt0_q;
    assign pkt_cnt1  = cnt1_q;
    assign m_tdata   = out_data[DATA_W-1:0];
    assign m_tlast   = out_data[DATA_W];

    // Steer the granted source into the buffer.
    always_comb begin
        in_valid = 1'b0;
        in_data  = {(DATA_W+1){1'b0}};
        case (state_q)
            GNT0: begin
                in_valid = s0_tvalid;
                in_data  = {s0_tlast, s0_tdata};
            end
            GNT1: begin
                in_valid = s1_tvalid;
                in_data  = {s1_tlast, s1_tdata};
            end
            default: begin
                in_valid = 1'b0;
                in_data  = {(DATA_W+1){1'b0}};
            end
        endcase
    end

    // Arbitration: decide only in IDLE, release on the accepted tlast beat.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        case (state_q)
            IDLE: begin
                if (s0_tvalid && s1_tvalid) begin
                    if (PRIORITY == PRIO_STRICT) begin
                        state_d = GNT0;
                    end else begin
                        state_d = rr_q ? GNT1 : GNT0;
                    end
                end else if (s0_tvalid) begin
                    state_d = GNT0;
                end else if (s1_tvalid) begin
                    state_d = GNT1;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT0: begin
                if (acc0 && s0_tlast) begin
                    state_d = IDLE;
                    rr_d    = 1'b1;
                    cnt0_d  = cnt0_q + CNT_W'(1);
                end else begin
                    state_d = GNT0;
                end
            end
            GNT1: begin
                if (acc1 && s1_tlast) begin
                    state_d = IDLE;
                    rr_d    = 1'b0;
                    cnt1_d  = cnt1_q + CNT_W'(1);
                end else begin
                    state_d = GNT1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbiter state, round-robin pointer and packet counters.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            cnt0_q  <= {CNT_W{1'b0}};
            cnt1_q  <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    axis_skid_buf #(
        .W (DATA_W + 1)
    ) u_skid (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_data  (in_data),
        .s_valid (in_valid),
        .s_ready (skid_ready),
        .m_data  (out_data),
        .m_valid (m_tvalid),
        .m_ready (m_tready)
    );

endmodule
